fifo_burst_packer: RTL and testbench
====================================

// Module: fifo_burst_packer
// PURPOSE
//  Read-side consumer of the 32-bit async gray FIFO. Runs in the FIFO read clock domain.
//  Watches the FIFO fill count and drains the FIFO in bursts of known length.
//  Each burst carries a length tag and a last flag, for DMA/AXI-style masters downstream.
//  Emits a full burst when MAX_BURST beats are available; a partial burst is emitted on flush (or timeout).
// PARAMETERS
//  DATA_WIDTH      32   beat width
//  CNT_WIDTH       11   width of FIFO fill count (LOG_DEPTH+1)
//  MAX_BURST       16   beats per full burst; power of two, 2..256
//  TIMEOUT_CYCLES  256  idle cycles with a partial FIFO before a partial burst is forced (timeout build only)
// PORTS
//  clk             in   1           read-domain clock
//  rst_n           in   1           asynchronous active-low reset
//  fifo_rvalid_i   in   1           FIFO head beat valid
//  fifo_rdata_i    in   DATA_WIDTH  FIFO head beat data
//  fifo_rready_o   out  1           pop FIFO head
//  fifo_cnt_i      in   CNT_WIDTH   FIFO fill count; lower bound of beats obtainable
//  flush_i         in   1           request a partial burst of all currently counted beats
//  m_valid_o       out  1           output beat valid
//  m_data_o        out  DATA_WIDTH  output beat data
//  m_last_o        out  1           final beat of burst
//  m_len_o         out  $clog2(MAX_BURST)  burst length minus 1; stable for the whole burst
//  m_ready_i       in   1           downstream accepts beat
//  busy_o          out  1           burst in progress (state != IDLE or output reg full)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, beat counter 0, timeout counter 0, output register empty. Reset takes effect immediately (asynchronous).
//  FSM IDLE:
//   fifo_cnt_i>=MAX_BURST -> BURST with len=MAX_BURST.
//   Else flush_i && fifo_cnt_i!=0 (or timeout) -> BURST with len=fifo_cnt_i.
//   A full burst wins over a simultaneous flush.
//   flush_i with fifo_cnt_i==0 is ignored, not remembered.
//  FSM BURST:
//   fifo_rready_o = output register empty or being drained this cycle (m_ready_i).
//   Each pop (fifo_rvalid_i && fifo_rready_o) loads the output register and decrements the beats-left counter.
//   Popping the final beat sets m_last_o on that beat and returns the FSM to IDLE next cycle.
//  fifo_rready_o is 0 in IDLE. The FIFO is never popped beyond len beats.
//  Output register: m_valid_o/m_data_o/m_last_o/m_len_o are held stable until m_valid_o && m_ready_i.
//   Full throughput is one beat per cycle while m_ready_i=1.
//   The next burst may start while the last beat of the previous burst still waits in the output register.
//  m_len_o is latched at the IDLE->BURST transition. It stays unchanged until the next burst starts.
//  Latency: count condition seen in cycle N -> BURST and fifo_rready_o=1 in N+1 -> first m_valid_o in N+2 (FIFO valid, sink ready).
//  flush_i during BURST is ignored. fifo_cnt_i changes during BURST do not alter len.
//  Beat counter width is $clog2(MAX_BURST)+1. fifo_cnt_i is compared at full CNT_WIDTH. No wrap is possible.
//  Backpressure mid-burst (m_ready_i=0) stalls popping. No beats are dropped or duplicated.
//  Reset mid-burst abandons the burst. Beats already popped are lost; the FIFO flushes on its own reset.
// CONFIGURATION
//  FIFO_BURST_PACKER_TIMEOUT_EN defined:
//   In IDLE with 0<fifo_cnt_i<MAX_BURST, a timeout counter increments each cycle.
//   It clears on fifo_cnt_i==0 or on entering BURST.
//   On reaching TIMEOUT_CYCLES-1 it acts as flush_i.
//  Macro undefined:
//   No timeout counter. Partial bursts are emitted only on flush_i.
// TESTING
//  1. Push 16 beats 0..15, m_ready_i=1 -> one burst of 16 beats, m_len_o=15, data 0..15, m_last_o on beat 15 only.
//  2. Push 40 beats, no flush -> two 16-beat bursts; 8 beats remain, fifo_cnt_i=8, packer idle (untimed build).
//  3. 5 beats present, pulse flush_i -> burst m_len_o=4, 5 beats, last on 5th; flush_i with cnt=0 -> no output.
//  4. Full burst, toggle m_ready_i randomly 50% -> 16 beats in order, data/last/len stable while stalled.
//  5. Timeout build, 3 beats, wait 256 cycles -> burst m_len_o=2 starts; untimed build -> nothing after 1000 cycles.
//  6. Assert rst_n=0 at beat 7 of a burst -> all outputs 0 immediately; after release, a new 16-beat burst is correct.

Source files
------------

// File: rtl/fifo_burst_packer.sv
// Read-side burst packer: drains an async FIFO in length-tagged bursts with a last flag.
// Optional idle timeout that forces a partial burst: define FIFO_BURST_PACKER_TIMEOUT_EN.
module fifo_burst_packer #(
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 11,
    parameter int MAX_BURST      = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         fifo_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        fifo_rdata_i,
    output logic                         fifo_rready_o,
    input  logic [CNT_WIDTH-1:0]         fifo_cnt_i,
    input  logic                         flush_i,
    output logic                         m_valid_o,
    output logic [DATA_WIDTH-1:0]        m_data_o,
    output logic                         m_last_o,
    output logic [$clog2(MAX_BURST)-1:0] m_len_o,
    input  logic                         m_ready_i,
    output logic                         busy_o
);
    // state | meaning
    // IDLE  | waiting for a full burst, a flush or a timeout; FIFO not popped
    // BURST | popping beats_q more beats into the output register
    localparam int LEN_W  = $clog2(MAX_BURST);
    localparam int BEAT_W = LEN_W + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beats_q, beats_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic                    ov_q, ov_d;
    logic [DATA_WIDTH-1:0]   od_q, od_d;
    logic                    ol_q, ol_d;
    logic [LEN_W-1:0]        olen_q, olen_d;
    logic                    rready;
    logic                    pop;
    logic                    start_full;
    logic                    start_part;
    logic                    tmo_hit;

    assign start_full = (fifo_cnt_i >= CNT_WIDTH'(MAX_BURST));
    assign start_part = (flush_i || tmo_hit) && (fifo_cnt_i != '0);

`ifdef FIFO_BURST_PACKER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;

    assign tmo_hit = (state_q == IDLE) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else if (state_q != IDLE || fifo_cnt_i == '0 || start_full || start_part) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end
`else
    // Constant false; keeps TIMEOUT_CYCLES referenced in the untimed build.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d = state_q;
        beats_d = beats_q;
        len_d   = len_q;
        ov_d    = ov_q && !m_ready_i;
        od_d    = od_q;
        ol_d    = ol_q;
        olen_d  = olen_q;
        rready  = 1'b0;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_full) begin
                    state_d = BURST;
                    beats_d = BEAT_W'(MAX_BURST);
                    len_d   = LEN_W'(MAX_BURST - 1);
                end else if (start_part) begin
                    state_d = BURST;
                    beats_d = BEAT_W'(fifo_cnt_i);
                    len_d   = LEN_W'(fifo_cnt_i - CNT_WIDTH'(1));
                end
            end
            BURST: begin
                rready = !ov_q || m_ready_i;
                pop    = rready && fifo_rvalid_i;
                if (pop) begin
                    ov_d    = 1'b1;
                    od_d    = fifo_rdata_i;
                    ol_d    = (beats_q == BEAT_W'(1));
                    olen_d  = len_q;
                    beats_d = beats_q - BEAT_W'(1);
                    if (beats_q == BEAT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beats_q <= '0;
            len_q   <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            olen_q  <= '0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            len_q   <= len_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            olen_q  <= olen_d;
        end
    end

    assign fifo_rready_o = rready;
    assign m_valid_o     = ov_q;
    assign m_data_o      = od_q;
    assign m_last_o      = ol_q;
    assign m_len_o       = olen_q;
    assign busy_o        = (state_q != IDLE) || ov_q;

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Directed bench for fifo_burst_packer with a behavioural FIFO in front of it.
module tb_fifo_burst_packer;
    localparam int DW = 32;
    localparam int CW = 11;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_rvalid_i = 1'b0;
    logic [DW-1:0] fifo_rdata_i = '0;
    logic          fifo_rready_o;
    logic [CW-1:0] fifo_cnt_i = '0;
    logic          flush_i = 1'b0;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic [LW-1:0] m_len_o;
    logic          m_ready_i = 1'b0;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q_fifo[$];
    logic [DW-1:0] rx_data[$];
    logic          rx_last[$];
    logic [LW-1:0] rx_len[$];
    logic          will_pop = 1'b0;

    fifo_burst_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rvalid_i (fifo_rvalid_i),
        .fifo_rdata_i  (fifo_rdata_i),
        .fifo_rready_o (fifo_rready_o),
        .fifo_cnt_i    (fifo_cnt_i),
        .flush_i       (flush_i),
        .m_valid_o     (m_valid_o),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o),
        .m_len_o       (m_len_o),
        .m_ready_i     (m_ready_i),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    function automatic void drive_fifo();
        fifo_cnt_i    = CW'(q_fifo.size());
        fifo_rvalid_i = (q_fifo.size() != 0);
        fifo_rdata_i  = (q_fifo.size() != 0) ? q_fifo[0] : '0;
    endfunction

    task automatic push_n(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) q_fifo.push_back(base + DW'(i));
        drive_fifo();
    endtask

    task automatic rx_clear();
        rx_data.delete();
        rx_last.delete();
        rx_len.delete();
    endtask

    // FIFO model and output monitor: inputs settle at negedge, handshakes sampled 1ns later.
    always @(negedge clk) begin
        if (will_pop && q_fifo.size() != 0) void'(q_fifo.pop_front());
        drive_fifo();
        #1;
        will_pop = rst_n && fifo_rvalid_i && fifo_rready_o;
        if (rst_n && m_valid_o && m_ready_i) begin
            rx_data.push_back(m_data_o);
            rx_last.push_back(m_last_o);
            rx_len.push_back(m_len_o);
        end
    end

    task automatic wait_rx(input int n, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            #2;
            if (rx_data.size() >= n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({m_valid_o, m_last_o, fifo_rready_o, busy_o} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000", {m_valid_o, m_last_o, fifo_rready_o, busy_o});
        end
        checks++;
        if ({m_data_o, m_len_o} !== '0) begin
            errors++;
            $display("FAIL reset_data_len got %0h/%0h want 0/0", m_data_o, m_len_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_burst();
        bit to;
        rx_clear();
        @(negedge clk);
        m_ready_i = 1'b1;
        push_n(16, 32'd0);
        #2;
        checks++;
        if (fifo_rready_o !== 1'b0) begin
            errors++;
            $display("FAIL lat_idle_rready got %b want 0", fifo_rready_o);
        end
        @(negedge clk);
        #2;
        checks++;
        if ({fifo_rready_o, m_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL lat_burst_rready got %b want 10", {fifo_rready_o, m_valid_o});
        end
        @(negedge clk);
        #2;
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'd0) begin
            errors++;
            $display("FAIL lat_first_beat got v=%b d=%0h want v=1 d=0", m_valid_o, m_data_o);
        end
        wait_rx(16, 100, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL full_timeout got %0d beats want 16", rx_data.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if ({rx_data[i], rx_last[i], rx_len[i]} !== {DW'(i), (i == 15), 4'd15}) begin
                    errors++;
                    $display("FAIL full_beat%0d got d=%0h l=%b n=%0d want d=%0h l=%b n=15",
                             i, rx_data[i], rx_last[i], rx_len[i], i, (i == 15));
                end
            end
        end
        repeat (4) @(negedge clk);
        #2;
        checks++;
        if (rx_data.size() != 16 || q_fifo.size() != 0 || busy_o !== 1'b0 || m_len_o !== 4'd15) begin
            errors++;
            $display("FAIL full_after got rx=%0d fifo=%0d busy=%b len=%0d want 16/0/0/15",
                     rx_data.size(), q_fifo.size(), busy_o, m_len_o);
        end
    endtask

    task automatic test_two_bursts();
        bit to;
        rx_clear();
        @(negedge clk);
        push_n(40, 32'd100);
        wait_rx(32, 200, to);
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (to || rx_data.size() != 32 || fifo_cnt_i !== 11'd8 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL two_bursts got rx=%0d cnt=%0d busy=%b want 32/8/0",
                     rx_data.size(), fifo_cnt_i, busy_o);
        end
        if (!to) begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if ({rx_data[i], rx_last[i], rx_len[i]} !== {DW'(100 + i), (i % 16 == 15), 4'd15}) begin
                    errors++;
                    $display("FAIL two_beat%0d got d=%0h l=%b n=%0d", i, rx_data[i], rx_last[i], rx_len[i]);
                end
            end
        end
    endtask

    task automatic test_flush();
        bit to;
        // drain the 8 beats left by the previous test
        rx_clear();
        pulse_flush();
        wait_rx(8, 100, to);
        checks++;
        if (to || rx_len[0] !== 4'd7 || rx_last[7] !== 1'b1 || rx_data[7] !== 32'd139) begin
            errors++;
            $display("FAIL flush8 got n=%0d beats len=%0d want 8 beats len=7", rx_data.size(),
                     (rx_data.size() != 0) ? rx_len[0] : 4'd0);
        end
        rx_clear();
        @(negedge clk);
        push_n(5, 32'd200);
        pulse_flush();
        wait_rx(5, 100, to);
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (to || rx_data.size() != 5) begin
            errors++;
            $display("FAIL flush5_count got %0d want 5", rx_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if ({rx_data[i], rx_last[i], rx_len[i]} !== {DW'(200 + i), (i == 4), 4'd4}) begin
                    errors++;
                    $display("FAIL flush5_beat%0d got d=%0h l=%b n=%0d", i, rx_data[i], rx_last[i], rx_len[i]);
                end
            end
        end
        // flush with an empty FIFO must be dropped, not remembered
        rx_clear();
        pulse_flush();
        repeat (5) @(negedge clk);
        push_n(3, 32'd300);
        repeat (20) @(negedge clk);
        #2;
        checks++;
        if (rx_data.size() != 0 || busy_o !== 1'b0 || q_fifo.size() != 3) begin
            errors++;
            $display("FAIL flush_empty got rx=%0d busy=%b fifo=%0d want 0/0/3",
                     rx_data.size(), busy_o, q_fifo.size());
        end
        pulse_flush();
        wait_rx(3, 100, to);
        checks++;
        if (to || rx_len[0] !== 4'd2 || rx_last[2] !== 1'b1 || rx_data[0] !== 32'd300) begin
            errors++;
            $display("FAIL flush3 got %0d beats want 3 beats len=2", rx_data.size());
        end
        // full burst beats a simultaneous flush
        rx_clear();
        @(negedge clk);
        push_n(20, 32'd400);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        wait_rx(16, 100, to);
        repeat (5) @(negedge clk);
        #2;
        checks++;
        if (to || rx_data.size() != 16 || rx_len[0] !== 4'd15 || rx_last[15] !== 1'b1 || q_fifo.size() != 4) begin
            errors++;
            $display("FAIL full_wins got rx=%0d fifo=%0d want 16/4", rx_data.size(), q_fifo.size());
        end
        rx_clear();
        pulse_flush();
        wait_rx(4, 100, to);
        checks++;
        if (to || rx_len[3] !== 4'd3 || rx_data[3] !== 32'd419 || rx_last[3] !== 1'b1) begin
            errors++;
            $display("FAIL flush4 got %0d beats want 4 beats len=3", rx_data.size());
        end
    endtask

    task automatic test_backpressure();
        logic          prev_stall = 1'b0;
        logic [DW-1:0] pd = '0;
        logic          pl = 1'b0;
        logic [LW-1:0] pn = '0;
        rx_clear();
        @(negedge clk);
        push_n(16, 32'd500);
        for (int c = 0; c < 400 && rx_data.size() < 16; c++) begin
            @(negedge clk);
            m_ready_i = 1'($urandom_range(0, 1));
            #2;
            if (prev_stall) begin
                checks++;
                if (m_valid_o !== 1'b1 || {m_data_o, m_last_o, m_len_o} !== {pd, pl, pn}) begin
                    errors++;
                    $display("FAIL bp_stable got v=%b d=%0h l=%b n=%0d want v=1 d=%0h l=%b n=%0d",
                             m_valid_o, m_data_o, m_last_o, m_len_o, pd, pl, pn);
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            pd = m_data_o;
            pl = m_last_o;
            pn = m_len_o;
        end
        @(negedge clk);
        m_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        checks++;
        if (rx_data.size() != 16) begin
            errors++;
            $display("FAIL bp_count got %0d want 16", rx_data.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if ({rx_data[i], rx_last[i], rx_len[i]} !== {DW'(500 + i), (i == 15), 4'd15}) begin
                    errors++;
                    $display("FAIL bp_beat%0d got d=%0h l=%b n=%0d", i, rx_data[i], rx_last[i], rx_len[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit to;
        rx_clear();
        @(negedge clk);
        push_n(3, 32'd600);
`ifdef FIFO_BURST_PACKER_TIMEOUT_EN
        repeat (200) @(negedge clk);
        #2;
        checks++;
        if (rx_data.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL tmo_early got rx=%0d busy=%b want 0/0", rx_data.size(), busy_o);
        end
        wait_rx(3, 150, to);
        checks++;
        if (to || rx_len[0] !== 4'd2 || rx_last[2] !== 1'b1 || rx_data[2] !== 32'd602) begin
            errors++;
            $display("FAIL tmo_burst got %0d beats want 3 beats len=2", rx_data.size());
        end
`else
        repeat (1000) @(negedge clk);
        #2;
        checks++;
        if (rx_data.size() != 0 || busy_o !== 1'b0 || q_fifo.size() != 3) begin
            errors++;
            $display("FAIL no_tmo got rx=%0d busy=%b fifo=%0d want 0/0/3",
                     rx_data.size(), busy_o, q_fifo.size());
        end
        pulse_flush();
        wait_rx(3, 100, to);
        checks++;
        if (to || rx_len[0] !== 4'd2 || rx_last[2] !== 1'b1 || rx_data[2] !== 32'd602) begin
            errors++;
            $display("FAIL no_tmo_drain got %0d beats want 3 beats len=2", rx_data.size());
        end
`endif
    endtask

    task automatic test_reset_mid();
        bit to;
        rx_clear();
        @(negedge clk);
        push_n(16, 32'd700);
        wait_rx(7, 100, to);
        @(negedge clk);
        rst_n = 1'b0;
        q_fifo.delete();
        will_pop = 1'b0;
        drive_fifo();
        #2;
        checks++;
        if (to || {m_valid_o, m_last_o, fifo_rready_o, busy_o} !== 4'b0000 || {m_data_o, m_len_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid got v=%b l=%b r=%b b=%b d=%0h n=%0d want all 0",
                     m_valid_o, m_last_o, fifo_rready_o, busy_o, m_data_o, m_len_o);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rx_clear();
        push_n(16, 32'd800);
        wait_rx(16, 100, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL post_reset_timeout got %0d beats want 16", rx_data.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if ({rx_data[i], rx_last[i], rx_len[i]} !== {DW'(800 + i), (i == 15), 4'd15}) begin
                    errors++;
                    $display("FAIL post_reset_beat%0d got d=%0h l=%b n=%0d", i, rx_data[i], rx_last[i], rx_len[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_two_bursts();
        test_flush();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
